// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shifter, one bit position per clock through a shared register
//   clk, rst        clock and asynchronous active-high reset
//   start           request, sampled only when idle
//   a, b            operand and unsigned shift amount
//   shift_control   00/10 left, 01 arithmetic right, 11 logical right
//   busy            high while an operation is in progress
//   done            one-cycle pulse when x holds the result
//   x               result register, held until the next accepted start
module shift_sequencer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       shift_control,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] x
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, n;
   logic [1:0]       mode;
   logic             accept;
   // full-width compare so large amounts saturate instead of aliasing in the low bits
   assign n = (b >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH) : b[CNT_W-1:0];
   assign accept = (state == IDLE) && start;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end
   always_comb begin
      state_nxt = (state == IDLE)  ? (start ? ((n != '0) ? SHIFT : DONE) : IDLE) :
                  (state == SHIFT) ? ((cnt == CNT_W'(1)) ? DONE : SHIFT) : IDLE;
   end
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x    <= '0;
         cnt  <= '0;
         mode <= '0;
      end else if (accept) begin
         x    <= a;
         cnt  <= n;
         mode <= shift_control;
      end else if (state == SHIFT) begin
         x   <= (mode == 2'b01) ? {x[WIDTH-1], x[WIDTH-1:1]} :
                (mode == 2'b11) ? {1'b0, x[WIDTH-1:1]} : {x[WIDTH-2:0], 1'b0};
         cnt <= cnt - 1'b1;
      end
   end
endmodule
